// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: sequencer state and the bundle of latch/PC enables it drives.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic pc_w;
        logic ifid_w;
        logic idex_w;
        logic exmem_w;
        logic memwb_w;
        logic ifid_rst;
        logic idex_rst;
        logic exmem_rst;
        logic memwb_rst;
    } seq_ctrl_t;

    localparam seq_ctrl_t CTRL_FREEZE = '0;

    localparam seq_ctrl_t CTRL_ADVANCE = '{
        pc_w: 1'b1, ifid_w: 1'b1, idex_w: 1'b1, exmem_w: 1'b1, memwb_w: 1'b1,
        ifid_rst: 1'b0, idex_rst: 1'b0, exmem_rst: 1'b0, memwb_rst: 1'b0
    };

    // Data-miss hold: front of the pipe frozen, bubble pushed into MEM/WB.
    localparam seq_ctrl_t CTRL_DSTALL = '{
        pc_w: 1'b0, ifid_w: 1'b0, idex_w: 1'b0, exmem_w: 1'b0, memwb_w: 1'b1,
        ifid_rst: 1'b0, idex_rst: 1'b0, exmem_rst: 1'b0, memwb_rst: 1'b1
    };

endpackage

// File: rtl/stall_counter.sv
// Saturating up-counter with synchronous enable and async active-low reset.
module stall_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_sequencer.sv
// Five-stage pipeline hazard sequencer: PC/latch enables, flushes, data-miss wait and halt.
// Define STALL_CNT_EN to include the saturating stall-cycle counter; otherwise stallCount is 0.
module pipe_sequencer
    import cpu_types_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   memREN,
    input  logic                   memWEN,
    input  logic                   exBranchTaken,
    input  logic                   idLoadUse,
    input  logic                   wbHalt,
    output logic                   pcW,
    output logic                   ifidW,
    output logic                   idexW,
    output logic                   exmemW,
    output logic                   memwbW,
    output logic                   ifidRST,
    output logic                   idexRST,
    output logic                   exmemRST,
    output logic                   memwbRST,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stallCount
);

    seq_state_t state_q;
    seq_state_t state_d;
    seq_ctrl_t  ctrl;
    logic       dmiss;

    assign dmiss = (memREN | memWEN) & ~dhit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (wbHalt)     state_d = HALTED;
                else if (dmiss) state_d = DWAIT;
            end
            DWAIT: begin
                if (wbHalt)     state_d = HALTED;
                else if (dhit)  state_d = RUN;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // A taken branch outranks load-use and fetch miss: the ID instruction is wrong-path anyway.
    always_comb begin
        ctrl = CTRL_FREEZE;
        unique case (state_q)
            RUN: begin
                if (wbHalt) begin
                    ctrl = CTRL_FREEZE;
                end else if (dmiss) begin
                    ctrl = CTRL_DSTALL;
                end else if (exBranchTaken) begin
                    ctrl          = CTRL_ADVANCE;
                    ctrl.ifid_rst = 1'b1;
                    ctrl.idex_rst = 1'b1;
                end else if (idLoadUse) begin
                    ctrl          = CTRL_ADVANCE;
                    ctrl.pc_w     = 1'b0;
                    ctrl.ifid_w   = 1'b0;
                    ctrl.idex_rst = 1'b1;
                end else if (!ihit) begin
                    ctrl          = CTRL_ADVANCE;
                    ctrl.pc_w     = 1'b0;
                    ctrl.ifid_rst = 1'b1;
                end else begin
                    ctrl = CTRL_ADVANCE;
                end
            end
            DWAIT: begin
                if (wbHalt)    ctrl = CTRL_FREEZE;
                else if (dhit) ctrl = CTRL_ADVANCE;
                else           ctrl = CTRL_DSTALL;
            end
            HALTED:  ctrl = CTRL_FREEZE;
            default: ctrl = CTRL_FREEZE;
        endcase
    end

    // Reset forces every enable low without waiting for a clock edge.
    assign pcW      = nRST & ctrl.pc_w;
    assign ifidW    = nRST & ctrl.ifid_w;
    assign idexW    = nRST & ctrl.idex_w;
    assign exmemW   = nRST & ctrl.exmem_w;
    assign memwbW   = nRST & ctrl.memwb_w;
    assign ifidRST  = nRST & ctrl.ifid_rst;
    assign idexRST  = nRST & ctrl.idex_rst;
    assign exmemRST = nRST & ctrl.exmem_rst;
    assign memwbRST = nRST & ctrl.memwb_rst;
    assign halted   = nRST & (state_q == HALTED);

`ifdef STALL_CNT_EN
    logic stall_en;

    assign stall_en = ~ctrl.pc_w & (state_q != HALTED);

    stall_counter #(
        .CNT_W (STALL_CNT_W)
    ) u_stall_counter (
        .clk     (CLK),
        .rst_n   (nRST),
        .en_i    (stall_en),
        .count_o (stallCount)
    );
`else
    assign stallCount = '0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer; expected controls queued per step and checked mid low-phase.
module tb_pipe_sequencer;

    localparam int unsigned CW = 4;
`ifdef STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST, halted}
    localparam logic [9:0] V_RST   = 10'b00000_0000_0;
    localparam logic [9:0] V_NORM  = 10'b11111_0000_0;
    localparam logic [9:0] V_FMISS = 10'b01111_1000_0;
    localparam logic [9:0] V_BR    = 10'b11111_1100_0;
    localparam logic [9:0] V_LU    = 10'b00111_0100_0;
    localparam logic [9:0] V_DMISS = 10'b00001_0001_0;
    localparam logic [9:0] V_HCYC  = 10'b00000_0000_0;
    localparam logic [9:0] V_HLT   = 10'b00000_0000_1;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b1, dhit = 1'b0, memREN = 1'b0, memWEN = 1'b0;
    logic exBranchTaken = 1'b0, idLoadUse = 1'b0, wbHalt = 1'b0;
    logic pcW, ifidW, idexW, exmemW, memwbW;
    logic ifidRST, idexRST, exmemRST, memwbRST, halted;
    logic [CW-1:0] stallCount;

    always #5 CLK = ~CLK;

    pipe_sequencer #(.STALL_CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .memREN(memREN), .memWEN(memWEN), .exBranchTaken(exBranchTaken),
        .idLoadUse(idLoadUse), .wbHalt(wbHalt),
        .pcW(pcW), .ifidW(ifidW), .idexW(idexW), .exmemW(exmemW), .memwbW(memwbW),
        .ifidRST(ifidRST), .idexRST(idexRST), .exmemRST(exmemRST), .memwbRST(memwbRST),
        .halted(halted), .stallCount(stallCount)
    );

    logic [9:0] obs;
    assign obs = {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST, halted};

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [9:0]    exp_q[$];
    logic [CW-1:0] cnt_q[$];
    string         tag_q[$];

    task automatic push_exp(input string tag, input logic [9:0] e);
        exp_q.push_back(e);
        cnt_q.push_back(CNT_ON ? CW'(exp_cnt) : '0);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        logic [9:0]    e;
        logic [CW-1:0] c;
        string         t;
        e = exp_q.pop_front();
        c = cnt_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s ctrl observed=%b expected=%b", t, obs, e);
        end
        n_cmp++;
        assert (stallCount === c) else begin
            n_err++;
            $error("FAIL %s stallCount observed=%0d expected=%0d", t, stallCount, c);
        end
    endtask

    task automatic step(input string tag, input logic ih, input logic dh, input logic rd,
                        input logic wr, input logic br, input logic lu, input logic hl,
                        input logic [9:0] e);
        @(negedge CLK);
        ihit = ih; dhit = dh; memREN = rd; memWEN = wr;
        exBranchTaken = br; idLoadUse = lu; wbHalt = hl;
        push_exp(tag, e);
        #1;
        check_out();
        if (!e[9] && !e[0] && exp_cnt < ((1 << CW) - 1)) exp_cnt++;
    endtask

    // Pulse reset inside the current low phase, check, then release at the next negedge.
    task automatic pulse_reset(input string tag);
        #2;
        nRST = 1'b0;
        #1;
        exp_cnt = 0;
        push_exp(tag, V_RST);
        check_out();
        @(negedge CLK);
        ihit = 1'b1; dhit = 1'b0; memREN = 1'b0; memWEN = 1'b0;
        exBranchTaken = 1'b0; idLoadUse = 1'b0; wbHalt = 1'b0;
        nRST = 1'b1;
    endtask

    initial begin
        #3;
        push_exp("reset_hold", V_RST);
        check_out();
        @(negedge CLK);
        nRST = 1'b1;

        step("normal",       1, 0, 0, 0, 0, 0, 0, V_NORM);
        step("fetch_miss",   0, 0, 0, 0, 0, 0, 0, V_FMISS);
        step("load_hit",     1, 1, 1, 0, 0, 0, 0, V_NORM);
        step("store_hit",    1, 1, 0, 1, 0, 0, 0, V_NORM);
        step("branch",       1, 0, 0, 0, 1, 0, 0, V_BR);
        step("branch_lu",    1, 0, 0, 0, 1, 1, 0, V_BR);
        step("branch_imiss", 0, 0, 0, 0, 1, 0, 0, V_BR);
        step("load_use",     1, 0, 0, 0, 0, 1, 0, V_LU);
        step("after_lu",     1, 0, 0, 0, 0, 0, 0, V_NORM);
        step("dmiss_br",     1, 0, 1, 0, 1, 1, 0, V_DMISS);
        step("dwait_hit",    1, 1, 0, 0, 0, 1, 0, V_NORM);
        step("back_run",     1, 0, 0, 0, 0, 0, 0, V_NORM);

        pulse_reset("reset_a");
        step("ld_miss1",     1, 0, 1, 0, 0, 0, 0, V_DMISS);
        step("ld_miss2",     1, 0, 1, 0, 0, 0, 0, V_DMISS);
        step("ld_miss3",     1, 0, 1, 0, 0, 0, 0, V_DMISS);
        step("ld_done",      1, 1, 1, 0, 0, 0, 0, V_NORM);
        step("ld_after",     1, 0, 0, 0, 0, 0, 0, V_NORM);

        for (int i = 0; i < 20; i++) begin
            step("sat_stall", 0, 0, 0, 0, 0, 0, 0, V_FMISS);
        end
        step("sat_hold",     1, 0, 0, 0, 0, 0, 0, V_NORM);

        step("st_miss1",     1, 0, 0, 1, 0, 0, 0, V_DMISS);
        step("st_miss2",     1, 0, 0, 0, 0, 0, 0, V_DMISS);
        pulse_reset("reset_in_dwait");
        step("post_rst_run", 1, 0, 0, 0, 0, 0, 0, V_NORM);

        step("h_miss1",      1, 0, 1, 0, 0, 0, 0, V_DMISS);
        step("h_miss2",      1, 0, 1, 0, 0, 0, 0, V_DMISS);
        step("halt_dwait",   1, 0, 1, 0, 0, 0, 1, V_HCYC);
        for (int i = 0; i < 10; i++) begin
            step("halted_frozen", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), V_HLT);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
